// File: rtl/cpu_timer_pkg.sv
// Shared constants for the millisecond timeout timer.
package cpu_timer_pkg;
  localparam int CLK_HZ     = 50_000_000;
  localparam int CYC_PER_MS = CLK_HZ / 1000;
  localparam int TMS_W      = 13;
  localparam int CNT_W      = 29;
endpackage

// File: rtl/cpu_timer_if.sv
// Request/flag bundle between a timeout requester and the cpu_timer block.
interface cpu_timer_if;
  import cpu_timer_pkg::*;

  // Tms is a level request (0 = stopped); rdy is a sticky level flag, no handshake.
  logic [TMS_W-1:0] Tms;
  logic             rdy;

  modport master (output Tms, input rdy);
  modport slave  (input Tms, output rdy);
endinterface

// File: rtl/cpu_timer.sv
// Millisecond timeout: rdy rises N = Tms*CYC_PER_MS edges after a run starts and stays set.
module cpu_timer
  import cpu_timer_pkg::*;
#(
  parameter int CLK_HZ     = cpu_timer_pkg::CLK_HZ,
  parameter int CYC_PER_MS = CLK_HZ / 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TMS_W-1:0] Tms,
  output logic             rdy
);

  logic [CNT_W-1:0] N;
  logic [CNT_W-1:0] count_reg;
  logic             rdy_reg;
  logic [TMS_W-1:0] Tms_q;
  logic             tms_zero;
  logic             tms_changed;

  // Max product (8191 * 50_000) fits in CNT_W bits, so no overflow is possible.
  assign N           = CNT_W'(Tms) * CNT_W'(CYC_PER_MS);
  assign tms_zero    = (Tms == '0);
  assign tms_changed = (Tms != Tms_q);
  assign rdy         = rdy_reg & ~tms_zero;

  // Free-running sample; it tracks Tms through reset so release never looks like a change.
  always_ff @(posedge clk) begin
    Tms_q <= Tms;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      rdy_reg   <= 1'b0;
    end else if (tms_zero || tms_changed) begin
      count_reg <= '0;
      rdy_reg   <= 1'b0;
    end else if (!rdy_reg) begin
      // Counter holds at N-1 once the flag is set; it never wraps.
      if (count_reg == N - CNT_W'(1)) begin
        rdy_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_timer.sv
// Bench for cpu_timer: scaled-down timer (10 cycles per ms) plus a default-parameter instance for N.
module tb_cpu_timer;
  import cpu_timer_pkg::*;

  localparam int TB_CYC = 10;

  logic             clk;
  logic             rst;
  logic [TMS_W-1:0] tms_def;
  logic             rdy_def;

  cpu_timer_if tif ();

  cpu_timer #(.CLK_HZ(TB_CYC * 1000), .CYC_PER_MS(TB_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .Tms (tif.Tms),
    .rdy (tif.rdy)
  );

  cpu_timer dut_def (
    .clk (clk),
    .rst (rst),
    .Tms (tms_def),
    .rdy (rdy_def)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0d expected <empty queue>", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Edges until rdy rises; returns budget if it never does so the check reports it.
  task automatic wait_rdy(input int budget, output int edges);
    edges = 0;
    while (tif.rdy !== 1'b1 && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [TMS_W-1:0] tms;
    logic [31:0]      exp_n;
    logic [31:0]      exp_n_def;
  } nvec_t;

  typedef struct {
    logic [TMS_W-1:0] tms;
    int               exp_edges;
  } rvec_t;

  nvec_t nv[5];
  rvec_t rv[4];

  initial begin
    int edges;

    nv[0] = '{tms: 13'd0,    exp_n: 32'd0,     exp_n_def: 32'd0};
    nv[1] = '{tms: 13'd1,    exp_n: 32'd10,    exp_n_def: 32'd50_000};
    nv[2] = '{tms: 13'd2,    exp_n: 32'd20,    exp_n_def: 32'd100_000};
    nv[3] = '{tms: 13'd8191, exp_n: 32'd81910, exp_n_def: 32'd409_550_000};
    nv[4] = '{tms: 13'd100,  exp_n: 32'd1000,  exp_n_def: 32'd5_000_000};

    rv[0] = '{tms: 13'd3,  exp_edges: 30};
    rv[1] = '{tms: 13'd7,  exp_edges: 70};
    rv[2] = '{tms: 13'd1,  exp_edges: 10};
    rv[3] = '{tms: 13'd50, exp_edges: 500};

    rst     = 1'b1;
    tif.Tms = 13'd100;
    tms_def = 13'd100;
    #1;

    // Reset state: N is combinational even while rst is high.
    check("reset_rdy", 32'(tif.rdy), 32'd0);
    check("reset_count", 32'(dut.count_reg), 32'd0);
    check("reset_n", 32'(dut.N), 32'd1000);
    check("reset_n_default", 32'(dut_def.N), 32'd5_000_000);

    foreach (nv[i]) begin
      tif.Tms = nv[i].tms;
      tms_def = nv[i].tms;
      exp_q.push_back(nv[i].exp_n);
      exp_q.push_back(nv[i].exp_n_def);
      tick();
      check_q($sformatf("n_tms%0d", nv[i].tms), 32'(dut.N));
      check_q($sformatf("n_default_tms%0d", nv[i].tms), 32'(dut_def.N));
      check($sformatf("rst_rdy_tms%0d", nv[i].tms), 32'(tif.rdy), 32'd0);
      check($sformatf("rst_count_tms%0d", nv[i].tms), 32'(dut.count_reg), 32'd0);
    end
    tms_def = 13'd0;
    ticks(2);

    // Release with Tms=100: rdy must rise on exactly the 1000th edge.
    rst = 1'b0;
    ticks(999);
    check("run100_rdy_before", 32'(tif.rdy), 32'd0);
    check("run100_count_before", 32'(dut.count_reg), 32'd999);
    tick();
    check("run100_rdy_at_n", 32'(tif.rdy), 32'd1);

    // Sticky flag; counter parked at N-1.
    ticks(500);
    check("sticky_rdy", 32'(tif.rdy), 32'd1);
    check("sticky_count", 32'(dut.count_reg), 32'd999);

    // Tms=0 drops rdy combinationally, then clears the counter.
    tif.Tms = 13'd0;
    #1;
    check("stop_rdy_immediate", 32'(tif.rdy), 32'd0);
    check("stop_n", 32'(dut.N), 32'd0);
    tick();
    check("stop_count", 32'(dut.count_reg), 32'd0);
    ticks(5);
    check("stop_count_held", 32'(dut.count_reg), 32'd0);
    check("stop_rdy_held", 32'(tif.rdy), 32'd0);

    // Tms=1 run, switched to Tms=2 part-way through.
    tif.Tms = 13'd1;
    tick();
    check("t1_start_count", 32'(dut.count_reg), 32'd0);
    ticks(6);
    check("t1_mid_count", 32'(dut.count_reg), 32'd6);
    tif.Tms = 13'd2;
    tick();
    check("t2_change_count", 32'(dut.count_reg), 32'd0);
    check("t2_change_rdy", 32'(tif.rdy), 32'd0);
    exp_q.push_back(32'd20);
    wait_rdy(100, edges);
    check_q("t2_edges_to_rdy", 32'(edges));

    // Table of runs, each started from a stopped timer.
    foreach (rv[i]) begin
      tif.Tms = 13'd0;
      tick();
      tif.Tms = rv[i].tms;
      tick();
      exp_q.push_back(32'(rv[i].exp_edges));
      wait_rdy(2 * rv[i].exp_edges + 10, edges);
      check_q($sformatf("run_tms%0d_edges", rv[i].tms), 32'(edges));
      ticks(5);
      check($sformatf("run_tms%0d_sticky", rv[i].tms), 32'(tif.rdy), 32'd1);
    end

    // Nonzero to nonzero change while rdy is already set.
    tif.Tms = 13'd49;
    tick();
    check("retarget_rdy_cleared", 32'(tif.rdy), 32'd0);
    check("retarget_count_cleared", 32'(dut.count_reg), 32'd0);
    exp_q.push_back(32'd490);
    wait_rdy(1000, edges);
    check_q("retarget_edges", 32'(edges));

    // Asynchronous reset mid-run aborts; a full N is needed after release.
    tif.Tms = 13'd100;
    tick();
    ticks(400);
    check("midrun_count", 32'(dut.count_reg), 32'd400);
    #4;
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(dut.count_reg), 32'd0);
    check("async_rst_rdy", 32'(tif.rdy), 32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(999);
    check("rerun_rdy_before", 32'(tif.rdy), 32'd0);
    tick();
    check("rerun_rdy_at_n", 32'(tif.rdy), 32'd1);
    check("rerun_count", 32'(dut.count_reg), 32'd999);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
